// File: rtl/top_control_pkg.sv
// Shared definitions for the top_control processor: opcodes, FSM state codes,
// control word bit map and ALU op encodings.
package top_control_pkg;

    localparam int unsigned AddrW    = 9;
    localparam int unsigned DataW    = 16;
    localparam int unsigned MemDepth = 512;
    localparam int unsigned CtlW     = 20;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OpNop   = 4'h0;
    localparam logic [3:0] OpLdac  = 4'h1;
    localparam logic [3:0] OpStac  = 4'h2;
    localparam logic [3:0] OpLdar  = 4'h3;
    localparam logic [3:0] OpIncar = 4'h4;
    localparam logic [3:0] OpMvr   = 4'h5;
    localparam logic [3:0] OpAdd   = 4'h6;
    localparam logic [3:0] OpSub   = 4'h7;
    localparam logic [3:0] OpMul   = 4'h8;
    localparam logic [3:0] OpLdi   = 4'h9;
    localparam logic [3:0] OpJmp   = 4'hA;
    localparam logic [3:0] OpJnz   = 4'hB;
    localparam logic [3:0] OpEnd   = 4'hF;

    typedef enum logic [5:0] {
        StIdle   = 6'd0,
        StFetch1 = 6'd1,
        StFetch2 = 6'd2,
        StDecode = 6'd3,
        StExec   = 6'd4,
        StMem1   = 6'd5,
        StMem2   = 6'd6,
        StHalt   = 6'd7
    } state_e;

    typedef enum logic [1:0] {
        AluPass = 2'd0,
        AluAdd  = 2'd1,
        AluSub  = 2'd2,
        AluMul  = 2'd3
    } alu_op_e;

    // Control word bit positions; bits 19:12 are always zero
    localparam int unsigned CtlLdac  = 0;
    localparam int unsigned CtlStac  = 1;
    localparam int unsigned CtlLdar  = 2;
    localparam int unsigned CtlIncar = 3;
    localparam int unsigned CtlMvr   = 4;
    localparam int unsigned CtlAluWr = 5;   // AC <= alu_out, Z updated
    localparam int unsigned CtlLdi   = 6;
    localparam int unsigned CtlJmp   = 7;
    localparam int unsigned CtlJnz   = 8;
    localparam int unsigned CtlEnd   = 9;
    localparam int unsigned CtlAluLo = 10;  // 2-bit ALU op field [11:10]
    localparam int unsigned CtlAluHi = 11;

endpackage

// File: rtl/top_control_alu.sv
// ALU for top_control: pass / add / sub / mul on 16-bit operands, wrapping.
// MUL exists only when TOP_CONTROL_MUL_EN is defined; otherwise it is a pass.
module top_control_alu
    import top_control_pkg::*;
(
    input  logic [DataW-1:0] a,
    input  logic [DataW-1:0] b,
    input  alu_op_e          op,
    output logic [DataW-1:0] y
);

    // Combinational result select
    always_comb begin
        y = a;
        case (op)
            AluAdd:  y = a + b;
            AluSub:  y = a - b;
`ifdef TOP_CONTROL_MUL_EN
            AluMul:  y = a * b;  // low 16 bits of the product
`endif
            default: y = a;
        endcase
    end

endmodule

// File: rtl/top_control_block.sv
// top_control processor: IRAM/DRAM, external load/readout modes and a
// fetch/decode/execute FSM. Optional MUL controlled by TOP_CONTROL_MUL_EN.
module top_control_block
    import top_control_pkg::*;
#(
    parameter int unsigned PC_START = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              start_2,
    input  logic              start_3,
    input  logic              start_4,
    input  logic [AddrW-1:0]  addr_ext,
    input  logic              iram_write_ext,
    input  logic [DataW-1:0]  Data_in_ins,
    input  logic              dram_write_ext,
    input  logic [DataW-1:0]  Data_in_dram,
    input  logic              read_en_ext,
    output logic [DataW-1:0]  dram_in,
    output logic [DataW-1:0]  iram_in,
    output logic [DataW-1:0]  dram_out,
    output logic [DataW-1:0]  pc_out,
    output logic [DataW-1:0]  ar_out,
    output logic [CtlW-1:0]   control_out,
    output logic [5:0]        state,
    output logic [DataW-1:0]  data_in_pc,
    output logic [DataW-1:0]  alu_in_1,
    output logic [DataW-1:0]  alu_in_2,
    output logic [DataW-1:0]  alu_out,
    output logic              write_en,
    output logic [1:0]        read_en
);

    localparam logic [AddrW-1:0] PcStart = AddrW'(PC_START);

    logic [DataW-1:0] iram [MemDepth];
    logic [DataW-1:0] dram [MemDepth];

    state_e           state_q, state_d;
    logic [AddrW-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [DataW-1:0] ac_q, ac_d, r_q, r_d;
    logic [3:0]       ir_op_q, ir_op_d;
    logic [AddrW-1:0] ir_imm_q, ir_imm_d;
    logic             z_q, z_d;
    logic [CtlW-1:0]  ctl_q, ctl_d, ctl_dec;
    logic [DataW-1:0] dram_rd_q, iram_rd_q;

    logic             ext_mode, mode3, mode4, run;
    logic             jump_taken, iram_rd, dram_rd, iram_we, dram_we;
    logic [AddrW-1:0] pc_next, iram_addr, dram_addr;

    top_control_alu u_alu (
        .a  (ac_q),
        .b  (r_q),
        .op (alu_op_e'(ctl_q[CtlAluHi:CtlAluLo])),
        .y  (alu_out)
    );

    // Mode decode, memory steering and datapath outputs
    always_comb begin
        ext_mode   = start_2 | start_3 | start_4;
        mode3      = !start_2 && start_3;
        mode4      = !start_2 && !start_3 && start_4;
        run        = !ext_mode && start;
        jump_taken = (state_q == StExec) && (ctl_q[CtlJmp] || (ctl_q[CtlJnz] && !z_q));
        pc_next    = jump_taken ? ir_imm_q : pc_q + 9'd1;

        read_en = 2'b00;
        if (state_q == StFetch1) read_en = 2'b01;
        if (state_q == StMem1)   read_en = 2'b10;
        write_en = (state_q == StExec) && ctl_q[CtlStac] && !ext_mode;

        iram_addr = ext_mode ? addr_ext : pc_q;
        dram_addr = ext_mode ? addr_ext : ar_q;
        dram_out  = mode3 ? Data_in_dram : ac_q;
        iram_we   = start_2 && iram_write_ext;
        dram_we   = mode3 ? dram_write_ext : write_en;
        iram_rd   = (mode4 && read_en_ext) || (run && read_en[0]);
        dram_rd   = (mode4 && read_en_ext) || (run && read_en[1]);

        dram_in     = dram_rd_q;
        iram_in     = iram_rd_q;
        pc_out      = {7'b0, pc_q};
        ar_out      = {7'b0, ar_q};
        control_out = ctl_q;
        state       = state_q;
        data_in_pc  = {7'b0, pc_next};
        alu_in_1    = ac_q;
        alu_in_2    = r_q;
    end

    // Instruction decode into the control word
    always_comb begin
        ctl_dec = '0;
        case (ir_op_q)
            OpLdac:  ctl_dec[CtlLdac]  = 1'b1;
            OpStac:  ctl_dec[CtlStac]  = 1'b1;
            OpLdar:  ctl_dec[CtlLdar]  = 1'b1;
            OpIncar: ctl_dec[CtlIncar] = 1'b1;
            OpMvr:   ctl_dec[CtlMvr]   = 1'b1;
            OpAdd: begin
                ctl_dec[CtlAluWr]          = 1'b1;
                ctl_dec[CtlAluHi:CtlAluLo] = AluAdd;
            end
            OpSub: begin
                ctl_dec[CtlAluWr]          = 1'b1;
                ctl_dec[CtlAluHi:CtlAluLo] = AluSub;
            end
`ifdef TOP_CONTROL_MUL_EN
            OpMul: begin
                ctl_dec[CtlAluWr]          = 1'b1;
                ctl_dec[CtlAluHi:CtlAluLo] = AluMul;
            end
`endif
            OpLdi:   ctl_dec[CtlLdi] = 1'b1;
            OpJmp:   ctl_dec[CtlJmp] = 1'b1;
            OpJnz:   ctl_dec[CtlJnz] = 1'b1;
            OpEnd:   ctl_dec[CtlEnd] = 1'b1;
            default: ctl_dec = '0;  // NOP and unused opcodes
        endcase
    end

    // FSM next state and register updates; leaving run mode holds all registers
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ar_d     = ar_q;
        ac_d     = ac_q;
        r_d      = r_q;
        ir_op_d  = ir_op_q;
        ir_imm_d = ir_imm_q;
        z_d      = z_q;
        ctl_d    = ctl_q;
        if (!run) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pc_d    = PcStart;
                    state_d = StFetch1;
                end
                StFetch1: state_d = StFetch2;
                StFetch2: begin
                    ir_op_d  = iram_rd_q[15:12];
                    ir_imm_d = iram_rd_q[AddrW-1:0];
                    pc_d     = pc_next;
                    state_d  = StDecode;
                end
                StDecode: begin
                    ctl_d   = ctl_dec;
                    state_d = StExec;
                end
                StExec: begin
                    state_d = StFetch1;
                    if (ctl_q[CtlLdac]) state_d = StMem1;
                    if (ctl_q[CtlEnd])  state_d = StHalt;
                    if (ctl_q[CtlLdar]) ar_d = ir_imm_q;
                    if (ctl_q[CtlIncar]) ar_d = ar_q + 9'd1;
                    if (ctl_q[CtlMvr])  r_d = ac_q;
                    if (ctl_q[CtlAluWr]) begin
                        ac_d = alu_out;
                        z_d  = (alu_out == '0);
                    end
                    if (ctl_q[CtlLdi]) begin
                        ac_d = {7'b0, ir_imm_q};
                        z_d  = (ir_imm_q == '0);
                    end
                    if (jump_taken) pc_d = pc_next;
                end
                StMem1: state_d = StMem2;
                StMem2: begin
                    ac_d    = dram_rd_q;
                    z_d     = (dram_rd_q == '0);
                    state_d = StFetch1;
                end
                StHalt:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers and registered memory read ports
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= PcStart;
            ar_q      <= '0;
            ac_q      <= '0;
            r_q       <= '0;
            ir_op_q   <= '0;
            ir_imm_q  <= '0;
            z_q       <= 1'b0;
            ctl_q     <= '0;
            dram_rd_q <= '0;
            iram_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            ac_q     <= ac_d;
            r_q      <= r_d;
            ir_op_q  <= ir_op_d;
            ir_imm_q <= ir_imm_d;
            z_q      <= z_d;
            ctl_q    <= ctl_d;
            if (dram_rd) dram_rd_q <= dram[dram_addr];
            if (iram_rd) iram_rd_q <= iram[iram_addr];
        end
    end

    // Memory write ports; contents survive reset
    always_ff @(posedge clock) begin
        if (iram_we) iram[iram_addr] <= Data_in_ins;
        if (dram_we) dram[dram_addr] <= dram_out;
    end

endmodule

// File: tb/tb_top_control_block.sv
// Directed testbench for top_control_block; honours TOP_CONTROL_MUL_EN.
module tb_top_control_block;
    import top_control_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, start_2 = 1'b0, start_3 = 1'b0, start_4 = 1'b0;
    logic [8:0]  addr_ext = '0;
    logic        iram_write_ext = 1'b0, dram_write_ext = 1'b0, read_en_ext = 1'b0;
    logic [15:0] Data_in_ins = '0, Data_in_dram = '0;
    logic [15:0] dram_in, iram_in, dram_out, pc_out, ar_out;
    logic [19:0] control_out;
    logic [5:0]  state;
    logic [15:0] data_in_pc, alu_in_1, alu_in_2, alu_out;
    logic        write_en;
    logic [1:0]  read_en;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [15:0] prog [$];
    logic [15:0] rd;

    top_control_block #(.PC_START(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .start_2        (start_2),
        .start_3        (start_3),
        .start_4        (start_4),
        .addr_ext       (addr_ext),
        .iram_write_ext (iram_write_ext),
        .Data_in_ins    (Data_in_ins),
        .dram_write_ext (dram_write_ext),
        .Data_in_dram   (Data_in_dram),
        .read_en_ext    (read_en_ext),
        .dram_in        (dram_in),
        .iram_in        (iram_in),
        .dram_out       (dram_out),
        .pc_out         (pc_out),
        .ar_out         (ar_out),
        .control_out    (control_out),
        .state          (state),
        .data_in_pc     (data_in_pc),
        .alu_in_1       (alu_in_1),
        .alu_in_2       (alu_in_2),
        .alu_out        (alu_out),
        .write_en       (write_en),
        .read_en        (read_en)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_prog();
        start = 1'b0;
        start_2 = 1'b1;
        iram_write_ext = 1'b1;
        for (int i = 0; i < prog.size(); i++) begin
            addr_ext = 9'(i + 1);
            Data_in_ins = prog[i];
            tick();
        end
        start_2 = 1'b0;
        iram_write_ext = 1'b0;
    endtask

    task automatic dram_read(input logic [8:0] a, output logic [15:0] d);
        start_4 = 1'b1;
        addr_ext = a;
        read_en_ext = 1'b1;
        tick();
        d = dram_in;
        start_4 = 1'b0;
        read_en_ext = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        int n;
        n = 0;
        we_cnt = 0;
        start = 1'b1;
        tick();
        chk({tag, "_fetch1"}, 32'(state), 32'(StFetch1));
        chk({tag, "_read_en"}, 32'(read_en), 32'd1);
        while (state !== StHalt && n < 400) begin
            if (write_en === 1'b1) we_cnt++;
            tick();
            n++;
        end
        chk({tag, "_halt"}, 32'(state), 32'(StHalt));
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_state", 32'(state), 32'(StIdle));
        chk("rst_pc", 32'(pc_out), 32'd1);
        chk("rst_ar", 32'(ar_out), 32'd0);
        chk("rst_ac", 32'(alu_in_1), 32'd0);
        chk("rst_r", 32'(alu_in_2), 32'd0);
        chk("rst_ctl", 32'(control_out), 32'd0);
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_re", 32'(read_en), 32'd0);
        chk("rst_dram_in", 32'(dram_in), 32'd0);
        chk("rst_iram_in", 32'(iram_in), 32'd0);
        chk("rst_dram_out", 32'(dram_out), 32'd0);
        reset = 1'b0;

        // Mode 2 write then mode 4 IRAM readout
        prog = '{16'h9005};
        load_prog();
        start_4 = 1'b1;
        addr_ext = 9'd1;
        read_en_ext = 1'b1;
        tick();
        chk("m4_iram_in", 32'(iram_in), 32'h9005);
        chk("m4_idle", 32'(state), 32'(StIdle));
        start_4 = 1'b0;
        read_en_ext = 1'b0;

        // Mode 3 DRAM write, mode 4 readout
        start_3 = 1'b1;
        addr_ext = 9'd10;
        Data_in_dram = 16'd7;
        dram_write_ext = 1'b1;
        #1;
        chk("m3_dram_out", 32'(dram_out), 32'd7);
        tick();
        start_3 = 1'b0;
        dram_write_ext = 1'b0;
        dram_read(9'd10, rd);
        chk("m4_dram10", 32'(rd), 32'd7);

        // LDAR 10; LDAC; MVR; ADD; INCAR; STAC; END
        prog = '{16'h300A, 16'h1000, 16'h5000, 16'h6000, 16'h4000, 16'h2000, 16'hF000};
        load_prog();
        run_to_halt("p1");
        chk("p1_pc", 32'(pc_out), 32'd8);
        chk("p1_ar", 32'(ar_out), 32'd11);
        chk("p1_ac", 32'(alu_in_1), 32'd14);
        chk("p1_r", 32'(alu_in_2), 32'd7);
        chk("p1_we_cycles", 32'(we_cnt), 32'd1);
        tick();
        tick();
        chk("p1_halt_hold", 32'(state), 32'(StHalt));
        start = 1'b0;
        tick();
        chk("p1_idle", 32'(state), 32'(StIdle));
        dram_read(9'd11, rd);
        chk("p1_dram11", 32'(rd), 32'd14);
        dram_read(9'd10, rd);
        chk("p1_dram10", 32'(rd), 32'd7);

        // LDI 1; MVR; LDI 3; SUB; JNZ 4; END
        prog = '{16'h9001, 16'h5000, 16'h9003, 16'h7000, 16'hB004, 16'hF000};
        load_prog();
        run_to_halt("p2");
        chk("p2_ac", 32'(alu_in_1), 32'd0);
        chk("p2_z", 32'(dut.z_q), 32'd1);
        chk("p2_pc", 32'(pc_out), 32'd7);
        start = 1'b0;
        tick();

        // LDI 300; MVR; MUL; opcode C (NOP); END
        prog = '{16'h912C, 16'h5000, 16'h8000, 16'hC000, 16'hF000};
        load_prog();
        run_to_halt("p3");
`ifdef TOP_CONTROL_MUL_EN
        chk("p3_mul_ac", 32'(alu_in_1), 32'h5F90);
`else
        chk("p3_mul_ac", 32'(alu_in_1), 32'd300);
`endif
        chk("p3_r", 32'(alu_in_2), 32'd300);
        chk("p3_z", 32'(dut.z_q), 32'd0);
        chk("p3_pc", 32'(pc_out), 32'd6);
        start = 1'b0;
        tick();

        // Reset in the middle of LDAC
        prog = '{16'h300A, 16'h1000, 16'hF000};
        load_prog();
        start = 1'b1;
        for (int n = 0; n < 50 && state !== StMem1; n++) tick();
        chk("p4_reach_mem1", 32'(state), 32'(StMem1));
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk("p4_rst_state", 32'(state), 32'(StIdle));
        chk("p4_rst_pc", 32'(pc_out), 32'd1);
        chk("p4_rst_ar", 32'(ar_out), 32'd0);
        reset = 1'b0;
        dram_read(9'd10, rd);
        chk("p4_dram10", 32'(rd), 32'd7);
        dram_read(9'd11, rd);
        chk("p4_dram11", 32'(rd), 32'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
